// File: rtl/div_sched.sv
// Round-robin front end that shares one free-running iterative divider among N_REQ requesters.
// Jobs move STAGED -> INFLIGHT -> 2-entry response FIFO; at most two jobs exist at any time.
module div_sched #(
    parameter  int N_REQ   = 4,
    parameter  int DIV_LAT = 33,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [32*N_REQ-1:0] req_dividend,
    input  logic [32*N_REQ-1:0] req_divisor,
    input  logic [N_REQ-1:0]    req_sign,
    output logic [N_REQ-1:0]    gnt,
    output logic [31:0]         div_dividend,
    output logic [31:0]         div_divider,
    output logic                div_sign,
    input  logic                div_ready,
    input  logic [31:0]         div_quotient,
    input  logic [31:0]         div_remainder,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [31:0]         rsp_quotient,
    output logic [31:0]         rsp_remainder,
    output logic                rsp_dbz,
    output logic                err_timeout
);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     quo;
        logic [31:0]     rem;
        logic            dbz;
    } rsp_t;

    localparam logic [5:0] WD_LIMIT = 6'(DIV_LAT);

    logic [31:0] dvd_arr [N_REQ];
    logic [31:0] dvs_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign dvd_arr[gi] = req_dividend[32*gi +: 32];
            assign dvs_arr[gi] = req_divisor[32*gi +: 32];
        end
    endgenerate

    logic            staged_q, staged_d;
    logic            inflight_q, inflight_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]     dvd_q, dvd_d;
    logic [31:0]     dvs_q, dvs_d;
    logic            sign_q, sign_d;
    logic [ID_W-1:0] stg_id_q, stg_id_d;
    logic            stg_dbz_q, stg_dbz_d;
    logic [ID_W-1:0] infl_id_q, infl_id_d;
    logic            infl_dbz_q, infl_dbz_d;
    rsp_t            fifo_q [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [5:0]      wd_q, wd_d;
    logic            err_q, err_d;

    logic [2:0]      outstanding;
    logic [ID_W-1:0] winner;
    logic            grant_ok;
    logic            push;
    logic            pop;
    rsp_t            push_entry;
    rsp_t            head;

    // First asserted request at or after the pointer, wrapping around.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] w;
        logic            found;
        int              idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && r[idx]) begin
                found = 1'b1;
                w     = ID_W'(idx);
            end
        end
        return w;
    endfunction

    always_comb begin
        outstanding = 3'(staged_q) + 3'(inflight_q) + 3'(cnt_q);
        winner      = rr_pick(req, rr_ptr_q);
        grant_ok    = rst_n && !staged_q && (outstanding < 3'd2) && (|req);
        gnt         = grant_ok ? (N_REQ'(1) << winner) : '0;
        rsp_valid   = (cnt_q != 2'd0);
        push        = div_ready && inflight_q;
        pop         = rsp_valid && rsp_ready;
        push_entry  = '{id: infl_id_q, quo: div_quotient, rem: div_remainder, dbz: infl_dbz_q};
        head        = fifo_q[rd_ptr_q];
    end

    always_comb begin
        staged_d   = staged_q;
        inflight_d = inflight_q;
        rr_ptr_d   = rr_ptr_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        sign_d     = sign_q;
        stg_id_d   = stg_id_q;
        stg_dbz_d  = stg_dbz_q;
        infl_id_d  = infl_id_q;
        infl_dbz_d = infl_dbz_q;
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        err_d      = err_q;

        // The divider swallows whatever is staged on every ready edge.
        if (div_ready) begin
            inflight_d = staged_q;
            infl_id_d  = stg_id_q;
            infl_dbz_d = stg_dbz_q;
            staged_d   = 1'b0;
        end

        // A grant coinciding with a ready edge stays staged until the next pulse.
        if (grant_ok) begin
            staged_d  = 1'b1;
            dvd_d     = dvd_arr[winner];
            dvs_d     = dvs_arr[winner];
            sign_d    = req_sign[winner];
            stg_id_d  = winner;
            stg_dbz_d = (dvs_arr[winner] == 32'd0);
            rr_ptr_d  = (winner == ID_W'(N_REQ-1)) ? '0 : winner + 1'b1;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        if (div_ready)   wd_d = '0;
        else if (&wd_q)  wd_d = wd_q;
        else             wd_d = wd_q + 6'd1;
        err_d = err_q | (inflight_q & (wd_d > WD_LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged_q   <= 1'b0;
            inflight_q <= 1'b0;
            rr_ptr_q   <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            sign_q     <= 1'b0;
            stg_id_q   <= '0;
            stg_dbz_q  <= 1'b0;
            infl_id_q  <= '0;
            infl_dbz_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            wd_q       <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
        end else begin
            staged_q   <= staged_d;
            inflight_q <= inflight_d;
            rr_ptr_q   <= rr_ptr_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            sign_q     <= sign_d;
            stg_id_q   <= stg_id_d;
            stg_dbz_q  <= stg_dbz_d;
            infl_id_q  <= infl_id_d;
            infl_dbz_q <= infl_dbz_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
            if (push) fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    assign div_dividend  = dvd_q;
    assign div_divider   = dvs_q;
    assign div_sign      = sign_q;
    assign rsp_id        = head.id;
    assign rsp_quotient  = head.quo;
    assign rsp_remainder = head.rem;
    assign rsp_dbz       = head.dbz;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural free-running divider that can be stalled.
module tb_div_sched;

    localparam int N_REQ   = 4;
    localparam int DIV_LAT = 33;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] req_dividend;
    logic [32*N_REQ-1:0] req_divisor;
    logic [N_REQ-1:0]    req_sign;
    logic [N_REQ-1:0]    gnt;
    logic [31:0]         div_dividend, div_divider;
    logic                div_sign, div_ready;
    logic [31:0]         div_quotient, div_remainder;
    logic                rsp_valid, rsp_ready;
    logic [1:0]          rsp_id;
    logic [31:0]         rsp_quotient, rsp_remainder;
    logic                rsp_dbz, err_timeout;

    div_sched #(.N_REQ(N_REQ), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_dividend(req_dividend),
        .req_divisor(req_divisor), .req_sign(req_sign), .gnt(gnt),
        .div_dividend(div_dividend), .div_divider(div_divider), .div_sign(div_sign),
        .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Divider model: loads on each ready edge, shows that result only during the next ready cycle.
    int          phase = 5;
    logic        stuck;
    logic [31:0] res_q_m = 32'd0;
    logic [31:0] res_r_m = 32'd0;

    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        logic signed [31:0] sa, sb;
        logic [31:0]        q, r;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    assign div_ready     = (phase == 0) && !stuck;
    assign div_quotient  = div_ready ? res_q_m : 32'hDEAD_BEEF;
    assign div_remainder = div_ready ? res_r_m : 32'hBAAD_F00D;

    always @(posedge clk) begin
        phase <= (phase == DIV_LAT-1) ? 0 : phase + 1;
        if (div_ready) {res_q_m, res_r_m} <= model_div(div_dividend, div_divider, div_sign);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] quo;
        logic [31:0] rem;
        logic        dbz;
        int          cyc;
    } rec_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edbz;
    } vec_t;

    rec_t rsp_log[$];
    int   gnt_log[$];
    int   g_grants = 0;
    int   g_pops   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
        req_dividend[32*id +: 32] = a;
        req_divisor[32*id +: 32]  = b;
        req_sign[id]              = s;
    endtask

    task automatic clear_logs();
        rsp_log.delete();
        gnt_log.delete();
    endtask

    // Runs up to max_cycles, logging grants and accepted responses; drops req after its grant.
    task automatic pump(input int max_cycles, input int want_rsp);
        int   g;
        rec_t r;
        for (int c = 0; c < max_cycles && rsp_log.size() < want_rsp; c++) begin
            @(negedge clk);
            g = -1;
            if (gnt != '0) begin
                for (int k = 0; k < N_REQ; k++) if (gnt[k]) g = k;
                check("gnt_onehot", 32'($countones(gnt)), 32'd1);
                check("gnt_cap", 32'((g_grants - g_pops) < 2), 32'd1);
                gnt_log.push_back(g);
                g_grants++;
                $display("grant id=%0d cycle=%0d", g, cyc);
            end
            if (rsp_valid && rsp_ready) begin
                r = '{id: int'(rsp_id), quo: rsp_quotient, rem: rsp_remainder,
                      dbz: rsp_dbz, cyc: cyc};
                rsp_log.push_back(r);
                g_pops++;
                $display("rsp id=%0d q=%08h r=%08h dbz=%0b cycle=%0d",
                         r.id, r.quo, r.rem, r.dbz, r.cyc);
            end
            tick();
            if (g >= 0) req[g] = 1'b0;
        end
    endtask

    vec_t vecs[7];
    logic [31:0] mq_q[4];
    logic [31:0] mq_r[4];

    initial begin
        vecs[0] = '{0, 32'd100,        32'd7,        1'b0, 32'd14,        32'd2,        1'b0};
        vecs[1] = '{1, 32'hFFFFFF9C,   32'd7,        1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE, 1'b0};
        vecs[2] = '{2, 32'd55,         32'd0,        1'b0, 32'hFFFFFFFF,  32'd55,       1'b1};
        vecs[3] = '{3, 32'hFFFFFFFF,   32'd16,       1'b0, 32'h0FFFFFFF,  32'd15,       1'b0};
        vecs[4] = '{1, 32'hFFFFFF9C,   32'hFFFFFFF9, 1'b1, 32'd14,        32'hFFFFFFFE, 1'b0};
        vecs[5] = '{2, 32'd100,        32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2,  32'd2,        1'b0};
        vecs[6] = '{3, 32'h80000000,   32'd2,        1'b0, 32'h40000000,  32'd0,        1'b0};
        mq_q = '{32'd3, 32'd6, 32'd9, 32'd13};
        mq_r = '{32'd0, 32'd1, 32'd2, 32'd0};

        rst_n = 1'b0; stuck = 1'b0; rsp_ready = 1'b1;
        req = '1; req_dividend = '0; req_divisor = '0; req_sign = '0;
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_dvd", div_dividend, 32'd0);
        check("rst_dvs", div_divider, 32'd0);
        check("rst_sign", 32'(div_sign), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_q", rsp_quotient, 32'd0);
        check("rst_rsp_r", rsp_remainder, 32'd0);
        check("rst_rsp_dbz", 32'(rsp_dbz), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        req = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single jobs, one at a time, with bounded grant-to-response latency.
        for (int i = 0; i < 7; i++) begin
            clear_logs();
            set_ops(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].s);
            req[vecs[i].id] = 1'b1;
            pump(2*DIV_LAT + 3, 1);
            check("vec_gnt_count", 32'(gnt_log.size()), 32'd1);
            if (gnt_log.size() > 0) check("vec_gnt_id", 32'(gnt_log[0]), 32'(vecs[i].id));
            check("vec_rsp_count", 32'(rsp_log.size()), 32'd1);
            if (rsp_log.size() > 0) begin
                check("vec_rsp_id", 32'(rsp_log[0].id), 32'(vecs[i].id));
                check("vec_rsp_q", rsp_log[0].quo, vecs[i].eq);
                check("vec_rsp_r", rsp_log[0].rem, vecs[i].er);
                check("vec_rsp_dbz", 32'(rsp_log[0].dbz), 32'(vecs[i].edbz));
            end
        end

        // All four requesters at once.
        clear_logs();
        for (int i = 0; i < 4; i++) set_ops(i, 32'(i*10 + 9), 32'd3, 1'b0);
        req = 4'b1111;
        pump(250, 4);
        check("mq_gnt_count", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < gnt_log.size(); i++) check("mq_gnt_order", 32'(gnt_log[i]), 32'(i));
        check("mq_rsp_count", 32'(rsp_log.size()), 32'd4);
        for (int i = 0; i < rsp_log.size(); i++) begin
            check("mq_rsp_id", 32'(rsp_log[i].id), 32'(i));
            check("mq_rsp_q", rsp_log[i].quo, mq_q[i]);
            check("mq_rsp_r", rsp_log[i].rem, mq_r[i]);
            if (i > 0) check("mq_spacing", 32'(rsp_log[i].cyc - rsp_log[i-1].cyc), 32'(DIV_LAT));
        end

        // Backpressure: FIFO fills with two results, third request must wait.
        clear_logs();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_ops(i, 32'(i*10 + 9), 32'd3, 1'b0);
        req = 4'b0111;
        pump(150, 99);
        check("bp_gnt_count", 32'(gnt_log.size()), 32'd2);
        check("bp_hold_valid", 32'(rsp_valid), 32'd1);
        check("bp_head_id", 32'(rsp_id), 32'd0);
        check("bp_head_q", rsp_quotient, 32'd3);
        rsp_ready = 1'b1;
        pump(200, 3);
        check("bp_gnt_total", 32'(gnt_log.size()), 32'd3);
        if (gnt_log.size() > 2) check("bp_third_gnt", 32'(gnt_log[2]), 32'd2);
        check("bp_rsp_count", 32'(rsp_log.size()), 32'd3);
        for (int i = 0; i < rsp_log.size(); i++) begin
            check("bp_rsp_id", 32'(rsp_log[i].id), 32'(i));
            check("bp_rsp_q", rsp_log[i].quo, mq_q[i]);
        end
        check("no_false_timeout", 32'(err_timeout), 32'd0);

        // Reset ten cycles after a grant discards the job.
        clear_logs();
        set_ops(0, 32'd100, 32'd7, 1'b0);
        req[0] = 1'b1;
        for (int c = 0; c < 80 && gnt_log.size() == 0; c++) pump(1, 99);
        check("mr_gnt", 32'(gnt_log.size()), 32'd1);
        pump(10, 99);
        rst_n = 1'b0;
        req   = '1;
        #1;
        check("mr_gnt_zero", 32'(gnt), 32'd0);
        check("mr_dvd_zero", div_dividend, 32'd0);
        check("mr_dvs_zero", div_divider, 32'd0);
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_err", 32'(err_timeout), 32'd0);
        repeat (3) tick();
        req    = '0;
        g_pops = g_grants;
        rst_n  = 1'b1;
        clear_logs();
        pump(120, 99);
        check("mr_no_rsp", 32'(rsp_log.size()), 32'd0);
        check("mr_no_gnt", 32'(gnt_log.size()), 32'd0);

        // Stall the divider with a job in flight.
        clear_logs();
        set_ops(1, 32'd100, 32'd7, 1'b0);
        req[1] = 1'b1;
        for (int c = 0; c < 80 && gnt_log.size() == 0; c++) pump(1, 99);
        check("wd_gnt", 32'(gnt_log.size()), 32'd1);
        begin
            bit loaded = 1'b0;
            for (int c = 0; c < 2*DIV_LAT && !loaded; c++) begin
                @(negedge clk);
                loaded = div_ready;
                tick();
            end
            check("wd_load_seen", 32'(loaded), 32'd1);
        end
        stuck = 1'b1;
        repeat (DIV_LAT) tick();
        @(negedge clk);
        check("wd_early", 32'(err_timeout), 32'd0);
        tick();
        @(negedge clk);
        check("wd_fire", 32'(err_timeout), 32'd1);
        tick();
        stuck = 1'b0;
        pump(100, 1);
        check("wd_late_rsp", 32'(rsp_log.size()), 32'd1);
        check("wd_sticky", 32'(err_timeout), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
